vadd_host_ctrl: RTL and testbench

Host-side controller for the vector-add kernel's `in_ready`/`out_ready` handshake. It fills the kernel's `a` and `b` operand arrays from one 32-bit input word stream and starts the kernel. It waits for completion, captures the `c` result array and streams it out word by word. It sits between the host data mover and the kernel, as the initiator side of the kernel's start/done protocol.

---
 rtl/vadd_host_ctrl_if.sv | 23 ++
 rtl/vadd_host_ctrl.sv | 172 +++++++++++++++++
 tb/tb_vadd_host_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_host_ctrl_if.sv
// Stream bundle between host data mover and vadd_host_ctrl.
// Carries the input word stream and the result word stream.
interface vadd_host_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/vadd_host_ctrl.sv
// Host-side start/done initiator for the vector-add kernel.
// Optional watchdog: define VADD_CTRL_TIMEOUT_EN.
module vadd_host_ctrl #(
  parameter int DATA_SIZE      = 16,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  vadd_host_ctrl_if.slave            host,
  output logic [DATA_SIZE*WIDTH-1:0] krnl_a,
  output logic [DATA_SIZE*WIDTH-1:0] krnl_b,
  input  logic [DATA_SIZE*WIDTH-1:0] krnl_c,
  output logic                       krnl_in_ready,
  input  logic                       krnl_out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_SIZE - 1);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q [DATA_SIZE];
  logic [WIDTH-1:0] b_q [DATA_SIZE];
  logic [WIDTH-1:0] c_q [DATA_SIZE];
  logic             s_fire;
  logic             m_fire;
  logic             to_hit;

  assign s_fire = host.s_valid && host.s_ready;
  assign m_fire = host.m_valid && host.m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_LOAD_A: begin
        if (s_fire) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (s_fire) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (krnl_out_ready) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else if (to_hit) begin
          idx_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_DRAIN: begin
        if (m_fire) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_LOAD_A;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_LOAD_A;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_LOAD_A;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < DATA_SIZE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (state_q == S_LOAD_A && s_fire)
        a_q[idx_q] <= host.s_data;
      if (state_q == S_LOAD_B && s_fire)
        b_q[idx_q] <= host.s_data;
      if (state_q == S_WAIT && krnl_out_ready) begin
        for (int i = 0; i < DATA_SIZE; i++)
          c_q[i] <= krnl_c[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < DATA_SIZE; g++) begin : g_flat
    assign krnl_a[g*WIDTH +: WIDTH] = a_q[g];
    assign krnl_b[g*WIDTH +: WIDTH] = b_q[g];
  end

  // Everything below is decoded straight from state so reset drops it at once.
  assign host.s_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign host.m_valid = (state_q == S_DRAIN);
  assign host.m_data  = (state_q == S_DRAIN) ? c_q[idx_q] : '0;
  assign host.m_last  = (state_q == S_DRAIN) && (idx_q == LAST);
  assign krnl_in_ready = (state_q == S_START) || (state_q == S_WAIT);
  assign busy = !((state_q == S_LOAD_A) && (idx_q == '0));
  assign done = done_q;

`ifdef VADD_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  assign to_hit = (state_q == S_WAIT) &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_START)
        cnt_q <= '0;
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (state_d == S_START && state_q == S_LOAD_B)
        err_q <= 1'b0;
      else if (to_hit && !krnl_out_ready)
        err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign to_hit = 1'b0;
  assign error  = 1'b0;
`endif

endmodule

// File: tb/tb_vadd_host_ctrl.sv
// Self-checking bench for vadd_host_ctrl with DATA_SIZE=4.
// Scoreboard of expected sums plus literal spot checks.
module tb_vadd_host_ctrl;
  localparam int DS = 4;
  localparam int W  = 32;

  typedef logic [W-1:0] vec_t [DS];

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  vadd_host_ctrl_if #(.WIDTH(W)) bus ();

  logic [DS*W-1:0] krnl_a, krnl_b;
  logic [DS*W-1:0] krnl_c = '0;
  logic krnl_in_ready, krnl_out_ready;
  logic busy, done, error;
  logic kern_done = 1'b0;
  logic spur = 1'b0;
  assign krnl_out_ready = kern_done | spur;

  vadd_host_ctrl #(
    .DATA_SIZE(DS), .WIDTH(W), .TIMEOUT_CYCLES(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .host(bus),
    .krnl_a(krnl_a), .krnl_b(krnl_b), .krnl_c(krnl_c),
    .krnl_in_ready(krnl_in_ready),
    .krnl_out_ready(krnl_out_ready),
    .busy(busy), .done(done), .error(error)
  );

  int errors = 0;
  int checks = 0;

  logic [2*DS*W-1:0] ops_q [$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  logic [2*DS*W-1:0] cur_ops = '0;
  int  beat = 0;
  bit  exp_done = 1'b0;
  int  done_cnt = 0;
  bit  kern_en = 1'b1;
  bit  stall_en = 1'b0;
  int  stall_cnt = 0;
  bit  prev_stall = 1'b0;
  bit  prev_inr = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic chk(input string nm,
                     input logic [DS*W-1:0] act,
                     input logic [DS*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DS*W-1:0] pack(input vec_t v);
    logic [DS*W-1:0] r;
    for (int i = 0; i < DS; i++) r[i*W +: W] = v[i];
    return r;
  endfunction

  task automatic flush();
    ops_q.delete();
    exp_q.delete();
    beat = 0;
    exp_done = 1'b0;
    prev_stall = 1'b0;
    prev_inr = 1'b0;
  endtask

  // Scoreboard compare, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        chk("done", done, exp_done);
        if (done) done_cnt++;
        chk("s_ready", bus.s_ready,
            !(krnl_in_ready || bus.m_valid));
        if (prev_stall) begin
          chk("stall_data", bus.m_data, prev_data);
          chk("stall_last", bus.m_last, prev_last);
        end
        if (krnl_in_ready) begin
          if (!prev_inr) begin
            checks++;
            if (ops_q.size() == 0) begin
              errors++;
              $display("FAIL start_unexpected: got 1 want 0");
            end else begin
              cur_ops = ops_q.pop_front();
            end
          end
          chk("krnl_a", krnl_a, cur_ops[DS*W-1:0]);
          chk("krnl_b", krnl_b, cur_ops[2*DS*W-1:DS*W]);
          chk("m_valid_in_wait", bus.m_valid, 0);
        end
        exp_done = 1'b0;
        if (bus.m_valid) begin
          chk("m_last", bus.m_last, beat == DS - 1);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL m_data_extra: got %0d want none",
                     bus.m_data);
          end else if (bus.m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL m_data: got %0d want %0d",
                     bus.m_data, exp_q[0]);
          end
          if (bus.m_ready) begin
            got_q.push_back(bus.m_data);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_done = (beat == DS - 1);
            beat = (beat + 1) % DS;
          end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data = bus.m_data;
        prev_last = bus.m_last;
        prev_inr = krnl_in_ready;
      end
    end
  end

  // Kernel model: answers c=a+b five cycles after start.
  initial begin
    int kcnt;
    kcnt = 0;
    forever begin
      @(posedge ap_clk);
      #1;
      kern_done = 1'b0;
      if (kern_en && ap_rst_n && krnl_in_ready) begin
        kcnt++;
        if (kcnt == 5) begin
          for (int i = 0; i < DS; i++)
            krnl_c[i*W +: W] = krnl_a[i*W +: W] + krnl_b[i*W +: W];
          kern_done = 1'b1;
        end
      end else begin
        kcnt = 0;
      end
    end
  end

  // Result sink with an optional 3-cycle stall at beat 2.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      if (stall_en && bus.m_valid && beat == 2 && stall_cnt < 3) begin
        bus.m_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.m_ready = 1'b1;
      end
    end
  end

  task automatic load(input vec_t a, input vec_t b,
                      input bit gap, input bit spur_b);
    bit ok;
    int t;
    ops_q.push_back({pack(b), pack(a)});
    for (int i = 0; i < DS; i++) exp_q.push_back(a[i] + b[i]);
    for (int i = 0; i < 2 * DS; i++) begin
      bus.s_data = (i < DS) ? a[i] : b[i-DS];
      bus.s_valid = 1'b1;
      spur = spur_b && (i == DS + 1);
      t = 0;
      do begin
        @(negedge ap_clk);
        ok = bus.s_ready;
        @(posedge ap_clk);
        #1;
        spur = 1'b0;
        t++;
      end while (!ok && t < 300);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: got s_ready 0 want 1");
        bus.s_valid = 1'b0;
        return;
      end
      if (gap) begin
        bus.s_valid = 1'b0;
        @(posedge ap_clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(posedge ap_clk);
      t++;
    end
    #1;
    chk("done_count", done_cnt, target);
  endtask

  task automatic check_got(input int base, input vec_t e);
    for (int i = 0; i < DS; i++) begin
      checks++;
      if (got_q.size() <= base + i) begin
        errors++;
        $display("FAIL res%0d: got none want %0d", base + i, e[i]);
      end else if (got_q[base+i] !== e[i]) begin
        errors++;
        $display("FAIL res%0d: got %0d want %0d",
                 base + i, got_q[base+i], e[i]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t a, b, e;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_in_ready", krnl_in_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk("rst_krnl_a", krnl_a, 0);
    chk("rst_krnl_b", krnl_b, 0);
    #1 ap_rst_n = 1'b1;

    // Basic run.
    a = '{32'd1, 32'd2, 32'd3, 32'd4};
    b = '{32'd10, 32'd20, 32'd30, 32'd40};
    load(a, b, 1'b0, 1'b0);
    chk("in_ready_rise", krnl_in_ready, 1);
    chk("busy_start", busy, 1);
    chk("krnl_a_lit", krnl_a,
        {32'd4, 32'd3, 32'd2, 32'd1});
    chk("krnl_b_lit", krnl_b,
        {32'd40, 32'd30, 32'd20, 32'd10});
    wait_done(1);
    e = '{32'd11, 32'd22, 32'd33, 32'd44};
    check_got(0, e);
    chk("idle_busy", busy, 0);
    chk("idle_error", error, 0);

    // Input gaps and output backpressure.
    got_q.delete();
    stall_en = 1'b1;
    stall_cnt = 0;
    a = '{32'd5, 32'd6, 32'd7, 32'd8};
    b = '{32'd100, 32'd200, 32'd300, 32'd400};
    load(a, b, 1'b1, 1'b0);
    wait_done(2);
    stall_en = 1'b0;
    e = '{32'd105, 32'd206, 32'd307, 32'd408};
    check_got(0, e);
    chk("stall_cycles", stall_cnt, 3);

    // Spurious kernel done in LOAD_B and in START.
    got_q.delete();
    a = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'd9};
    b = '{32'd1, 32'd2, 32'd1, 32'd9};
    load(a, b, 1'b0, 1'b1);
    spur = 1'b1;
    @(posedge ap_clk);
    #1;
    spur = 1'b0;
    chk("spur_in_ready", krnl_in_ready, 1);
    chk("spur_no_valid", bus.m_valid, 0);
    wait_done(3);
    e = '{32'd8, 32'd2, 32'd0, 32'd18};
    check_got(0, e);

    // Reset while waiting on the kernel.
    kern_en = 1'b0;
    a = '{32'd3, 32'd3, 32'd3, 32'd3};
    b = '{32'd4, 32'd4, 32'd4, 32'd4};
    load(a, b, 1'b0, 1'b0);
    repeat (3) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", krnl_in_ready, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_krnl_a", krnl_a, 0);
    chk("mid_rst_krnl_b", krnl_b, 0);
    flush();
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    kern_en = 1'b1;
    got_q.delete();
    a = '{32'd21, 32'd22, 32'd23, 32'd24};
    b = '{32'd1000, 32'd0, 32'd7, 32'd76};
    load(a, b, 1'b0, 1'b0);
    wait_done(4);
    e = '{32'd1021, 32'd22, 32'd30, 32'd100};
    check_got(0, e);

    // Two vectors with no idle gap.
    got_q.delete();
    a = '{32'd1, 32'd1, 32'd1, 32'd1};
    b = '{32'd2, 32'd3, 32'd4, 32'd5};
    load(a, b, 1'b0, 1'b0);
    a = '{32'd50, 32'd60, 32'd70, 32'd80};
    b = '{32'd5, 32'd6, 32'd7, 32'd8};
    load(a, b, 1'b0, 1'b0);
    wait_done(6);
    e = '{32'd3, 32'd4, 32'd5, 32'd6};
    check_got(0, e);
    e = '{32'd55, 32'd66, 32'd77, 32'd88};
    check_got(DS, e);

`ifdef VADD_CTRL_TIMEOUT_EN
    // Kernel never answers: watchdog fires after 8 WAIT cycles.
    kern_en = 1'b0;
    a = '{32'd9, 32'd9, 32'd9, 32'd9};
    b = '{32'd9, 32'd9, 32'd9, 32'd9};
    load(a, b, 1'b0, 1'b0);
    repeat (8) @(posedge ap_clk);
    #1;
    chk("to_pre_error", error, 0);
    chk("to_pre_in_ready", krnl_in_ready, 1);
    @(posedge ap_clk);
    #1;
    chk("to_error", error, 1);
    chk("to_in_ready", krnl_in_ready, 0);
    chk("to_m_valid", bus.m_valid, 0);
    chk("to_busy", busy, 0);
    chk("to_s_ready", bus.s_ready, 1);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("to_sticky", error, 1);
    chk("to_no_done", done_cnt, 6);
    exp_q.delete();
    kern_en = 1'b1;
    got_q.delete();
    a = '{32'd2, 32'd4, 32'd6, 32'd8};
    b = '{32'd1, 32'd1, 32'd1, 32'd1};
    load(a, b, 1'b0, 1'b0);
    chk("to_clear_start", error, 0);
    wait_done(7);
    e = '{32'd3, 32'd5, 32'd7, 32'd9};
    check_got(0, e);
`else
    chk("no_to_error", error, 0);
`endif

    repeat (3) @(posedge ap_clk);
    #1;
    chk("exp_drained", exp_q.size(), 0);
    chk("ops_drained", ops_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
